// File: rtl/tmds_pkg.sv
// Shared TMDS symbol tables, mode encoding and helpers
// for the multi-channel encoder.
package tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CTRL  = 2'b00,
    VIDEO = 2'b01,
    TERC4 = 2'b10,
    VGB   = 2'b11
  } tmds_mode_e;

  localparam logic [SYM_W-1:0] CTRL_SYM [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  // Stored as q[9:0], i.e. bit-reversed from the on-wire order
  localparam logic [SYM_W-1:0] TERC4_SYM [16] = '{
    10'b0011100101, 10'b1100011001,
    10'b0010011101, 10'b0100011101,
    10'b1000111010, 10'b0111100010,
    10'b0111000110, 10'b0011110010,
    10'b0011001101, 10'b1001110010,
    10'b0011100110, 10'b0110001101,
    10'b0111000101, 10'b1000111001,
    10'b1100011010, 10'b1100001101
  };

  localparam logic [SYM_W-1:0] VGB_SYM_A = 10'b0011001101;
  localparam logic [SYM_W-1:0] VGB_SYM_B = 10'b1100110010;

  function automatic logic [3:0] popcnt8(
    input logic [7:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder_mc_lane.sv
// One TMDS lane: stage-1 transition minimisation, stage-2
// DC balancing / symbol select. TERC4 needs TMDS_MC_TERC4_EN.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int LANE_IDX = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  tmds_mode_e        mode_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        ctrl_i,
  input  logic [3:0]        terc4_i,
  output logic [SYM_W-1:0]  q_o
);

  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
  localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);

  logic [3:0] n1_d;
  logic       xnor_d;
  logic [8:0] qm_d;

  tmds_mode_e mode_q;
  logic [1:0] ctrl_q;
  logic [8:0] qm_q;
  logic [3:0] n1_q;

  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [CNT_W-1:0] n1s, diff, two_p, two_n;
  logic [SYM_W-1:0]        q_q, q_d;
  logic                    bal, inv;

  always_comb begin
    n1_d   = popcnt8(data_i);
    xnor_d = (n1_d > 4'd4) ||
             (n1_d == 4'd4 && !data_i[0]);
    qm_d    = '0;
    qm_d[0] = data_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = xnor_d ? ~(qm_d[i-1] ^ data_i[i])
                       :  (qm_d[i-1] ^ data_i[i]);
    end
    qm_d[8] = ~xnor_d;
  end

`ifdef TMDS_MC_TERC4_EN
  logic [3:0] terc4_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      terc4_q <= '0;
    end else if (en_i) begin
      terc4_q <= terc4_i;
    end
  end
`else
  logic unused_terc4;
  assign unused_terc4 = ^terc4_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= CTRL;
      ctrl_q <= '0;
      qm_q   <= '0;
      n1_q   <= '0;
    end else if (en_i) begin
      mode_q <= mode_i;
      ctrl_q <= ctrl_i;
      qm_q   <= qm_d;
      n1_q   <= popcnt8(qm_d[7:0]);
    end
  end

  // N1 - N0 = 2*N1 - 8
  always_comb begin
    n1s   = {{(CNT_W-4){1'b0}}, n1_q};
    diff  = n1s + n1s - EIGHT;
    two_p = qm_q[8] ? TWO : '0;
    two_n = qm_q[8] ? '0 : TWO;
    bal   = (cnt_q == '0) || (n1_q == 4'd4);
    inv   = (!cnt_q[CNT_W-1] && n1_q > 4'd4) ||
            ( cnt_q[CNT_W-1] && n1_q < 4'd4);
  end

  always_comb begin
    q_d   = CTRL_SYM[ctrl_q];
    cnt_d = '0;
    unique case (mode_q)
      VIDEO: begin
        if (bal) begin
          q_d = {~qm_q[8], qm_q[8],
                 qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d = qm_q[8] ? cnt_q + diff
                          : cnt_q - diff;
        end else if (inv) begin
          q_d   = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d = cnt_q + two_p - diff;
        end else begin
          q_d   = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d = cnt_q - two_n + diff;
        end
      end
      VGB: begin
        q_d = (LANE_IDX % 3 == 1) ? VGB_SYM_B
                                  : VGB_SYM_A;
      end
`ifdef TMDS_MC_TERC4_EN
      TERC4: q_d = TERC4_SYM[terc4_q];
`endif
      default: q_d = CTRL_SYM[ctrl_q];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      q_q   <= CTRL_SYM[0];
    end else if (en_i) begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tmds_encoder_mc.sv
// NUM_CH-lane TMDS encoder top: bus slicing only.
// Define TMDS_MC_TERC4_EN to enable TERC4 data islands.
module tmds_encoder_mc
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic [8*NUM_CH-1:0]   data_i,
  input  logic [2*NUM_CH-1:0]   ctrl_i,
  input  logic [4*NUM_CH-1:0]   terc4_i,
  output logic [10*NUM_CH-1:0]  q_o
);

  if (CNT_W < 5) begin : g_bad_cnt_w
    $error("CNT_W must be at least 5");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
    $error("NUM_CH must be 1..4");
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    tmds_lane #(
      .CNT_W    (CNT_W),
      .LANE_IDX (k)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (en_i),
      .mode_i  (tmds_mode_e'(mode_i)),
      .data_i  (data_i[8*k +: 8]),
      .ctrl_i  (ctrl_i[2*k +: 2]),
      .terc4_i (terc4_i[4*k +: 4]),
      .q_o     (q_o[10*k +: 10])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Directed bench for tmds_encoder_mc (3 lanes, CNT_W=6),
// with a small golden model for the stalled video stream.
module tb_tmds_encoder_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] data;
  logic [5:0]  ctrl;
  logic [11:0] terc4;
  logic [29:0] q;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] VA  = 10'b0011001101;
  localparam logic [9:0] VB  = 10'b1100110010;
  localparam logic [9:0] Z0  = 10'b0100000000;
  localparam logic [9:0] Z1  = 10'b1111111111;
  localparam logic [9:0] F0  = 10'b1000000000;
  localparam logic [9:0] F1  = 10'b0011111111;

  // on-wire order, q[0] first (leftmost)
  logic [9:0] terc_wire [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100,
    10'b1011100010, 10'b0101110001, 10'b0100011110,
    10'b0110001110, 10'b0100111100, 10'b1011001100,
    10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011,
    10'b1011000011
  };

  tmds_encoder_mc #(
    .NUM_CH (3),
    .CNT_W  (6)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en),
    .mode_i  (mode),
    .data_i  (data),
    .ctrl_i  (ctrl),
    .terc4_i (terc4),
    .q_o     (q)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [1:0]  m,
    input logic [23:0] d,
    input logic [5:0]  c,
    input logic [11:0] t
  );
    mode  = m;
    data  = d;
    ctrl  = c;
    terc4 = t;
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  function automatic logic [9:0] enc(
    input  logic [7:0] d,
    input  int         ci,
    output int         co
  );
    int n1, m1;
    logic x;
    logic [8:0] m;
    logic [9:0] r;
    n1 = $countones(d);
    x  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    m[0] = d[0];
    for (int i = 1; i < 8; i++)
      m[i] = x ? ~(m[i-1] ^ d[i]) : (m[i-1] ^ d[i]);
    m[8] = ~x;
    m1 = $countones(m[7:0]);
    if (ci == 0 || m1 == 4) begin
      r  = {~m[8], m[8], m[8] ? m[7:0] : ~m[7:0]};
      co = ci + (m[8] ? 2*m1 - 8 : 8 - 2*m1);
    end else if ((ci > 0 && m1 > 4) || (ci < 0 && m1 < 4)) begin
      r  = {1'b1, m[8], ~m[7:0]};
      co = ci + (m[8] ? 2 : 0) + 8 - 2*m1;
    end else begin
      r  = {1'b0, m[8], m[7:0]};
      co = ci - (m[8] ? 0 : 2) + 2*m1 - 8;
    end
    return r;
  endfunction

  task automatic test_reset();
    logic [29:0] exp;
    rst_n = 1'b0;
    en    = 1'b1;
    drive(2'b00, '0, '0, '0);
    step();
    step();
    exp = {C00, C00, C00};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL reset: got %b want %b", q, exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ctrl();
    logic [29:0] exp;
    drive(2'b00, '0, 6'b00_00_01, '0);
    step();
    step();
    exp = {C00, C00, C01};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL ctrl_a: got %b want %b", q, exp);
    end
    drive(2'b00, '0, 6'b01_11_10, '0);
    step();
    step();
    exp = {C01, C11, C10};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL ctrl_b: got %b want %b", q, exp);
    end
  endtask

  task automatic test_video();
    logic [29:0] exp;
    drive(2'b00, '0, '0, '0);
    step();
    step();
    drive(2'b01, 24'h00_FF_00, '0, '0);
    step();
    step();
    exp = {Z0, F0, Z0};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL video_1: got %b want %b", q, exp);
    end
    step();
    exp = {Z1, F1, Z1};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL video_2: got %b want %b", q, exp);
    end
  endtask

  task automatic test_clear();
    logic [29:0] exp;
    drive(2'b00, '0, '0, '0);
    step();
    step();
    drive(2'b01, 24'hFF_FF_FF, '0, '0);
    step();
    drive(2'b00, '0, '0, '0);
    step();
    exp = {F0, F0, F0};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL clear_ff1: got %b want %b", q, exp);
    end
    drive(2'b01, 24'hFF_FF_FF, '0, '0);
    step();
    exp = {C00, C00, C00};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL clear_ctrl: got %b want %b", q, exp);
    end
    step();
    exp = {F0, F0, F0};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL clear_ff2: got %b want %b", q, exp);
    end
    step();
    exp = {F1, F1, F1};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL clear_ff3: got %b want %b", q, exp);
    end
  endtask

  task automatic test_terc4();
    logic [29:0] exp;
    drive(2'b00, '0, '0, '0);
    step();
    step();
    drive(2'b01, 24'hFF_FF_FF, '0, '0);
    step();
    drive(2'b10, '0, 6'b11_10_01, 12'h5F0);
    step();
    exp = {F0, F0, F0};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL terc4_pre: got %b want %b", q, exp);
    end
    step();
`ifdef TMDS_MC_TERC4_EN
    exp = {rev10(terc_wire[5]), rev10(terc_wire[15]),
           rev10(terc_wire[0])};
`else
    exp = {C11, C10, C01};
`endif
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL terc4_sym: got %b want %b", q, exp);
    end
    drive(2'b01, 24'hFF_FF_FF, '0, '0);
    step();
    step();
    exp = {F0, F0, F0};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL terc4_clr: got %b want %b", q, exp);
    end
  endtask

  task automatic test_vgb();
    logic [29:0] exp;
    drive(2'b11, 24'h12_34_56, '0, '0);
    step();
    step();
    exp = {VA, VB, VA};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL vgb: got %b want %b", q, exp);
    end
  endtask

  task automatic test_enable();
    logic [1:0]  sm [20];
    logic [23:0] sd [20];
    logic [29:0] so [20];
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int cnt [3];
    int co, e, idx, c;
    for (int j = 0; j < 20; j++) begin
      if (j < 2 || j >= 18) begin
        sm[j] = 2'b00;
        sd[j] = '0;
        so[j] = {C00, C00, C00};
        for (int k = 0; k < 3; k++) cnt[k] = 0;
      end else begin
        sm[j] = 2'b01;
        sd[j] = 24'($urandom);
        for (int k = 0; k < 3; k++) begin
          so[j][10*k +: 10] = enc(sd[j][8*k +: 8], cnt[k], co);
          cnt[k] = co;
        end
      end
    end
    e = 0;
    idx = 0;
    c = 0;
    drive(sm[0], sd[0], '0, '0);
    while (idx < 20 && c < 200) begin
      en = pat[c % 4];
      step();
      c++;
      if (en) begin
        e++;
        idx++;
        if (idx < 20) drive(sm[idx], sd[idx], '0, '0);
      end
      if (e >= 2) begin
        checks++;
        if (q !== so[e-2]) begin
          errors++;
          $display("FAIL enable[%0d]: got %b want %b",
                   e - 2, q, so[e-2]);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [29:0] exp;
    drive(2'b00, '0, '0, '0);
    step();
    step();
    drive(2'b01, 24'hFF_FF_FF, '0, '0);
    step();
    step();
    rst_n = 1'b0;
    #2;
    exp = {C00, C00, C00};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL rst_async: got %b want %b", q, exp);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL rst_first: got %b want %b", q, exp);
    end
    step();
    exp = {F0, F0, F0};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL rst_cnt0: got %b want %b", q, exp);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_video();
    test_clear();
    test_terc4();
    test_vgb();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
